// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU PC path: FSM states,
// exception cause codes and default vector/EPC constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_SAVE = 2'd1,
        EXC_JUMP = 2'd2
    } pc_state_t;

    localparam logic [1:0] EXC_OPCODE = 2'd0;
    localparam logic [1:0] EXC_OVF    = 2'd1;
    localparam logic [1:0] EXC_DIV0   = 2'd2;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_00FC;
    localparam int          EPC_OFFSET_DEF = 4;

endpackage

// File: rtl/pc_hist_buf.sv
// Circular buffer of the most recent PC redirect targets; read port is
// indexed backwards from the newest entry (0 = newest).
module pc_hist_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [IDX_W-1:0]  hist_idx,
    output logic [DATA_W-1:0] hist_data,
    output logic [IDX_W:0]    hist_cnt
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_ptr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q != (IDX_W+1)'(DEPTH)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries beyond hist_cnt are don't-care.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // DEPTH is a power of two, so the pointer arithmetic wraps for free.
    assign rd_ptr    = wr_ptr_q - 1'b1 - hist_idx;
    assign hist_data = mem_q[rd_ptr];
    assign hist_cnt  = cnt_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Next-PC selection, PC/EPC registers and the exception redirect FSM.
// Optional redirect-history buffer enabled with `define PC_HIST_EN.
module pc_redirect_unit
    import cpu_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 NUM_SRC    = 5,
    parameter int                 SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter logic [DATA_W-1:0]  RESET_PC   = '0,
    parameter logic [DATA_W-1:0]  VEC_BASE   = DATA_W'(VEC_BASE_DEF),
    parameter int                 EPC_OFFSET = EPC_OFFSET_DEF,
    parameter int                 HIST_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          pc_sel,
    input  logic                      pc_write,
    input  logic                      pc_write_cond,
    input  logic                      branch_taken,
    input  logic                      exc_req,
    input  logic [1:0]                exc_cause,
    input  logic                      eret,
    output logic [DATA_W-1:0]         pc_next,
    output logic [DATA_W-1:0]         pc_q,
    output logic [DATA_W-1:0]         epc_q,
    output logic                      exc_busy,
    output logic                      exc_done,
`ifdef PC_HIST_EN
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [DATA_W-1:0]             hist_data,
    output logic [$clog2(HIST_DEPTH):0]   hist_cnt,
`endif
    output logic                      sel_err
);

    pc_state_t         state_q, state_d;
    logic [DATA_W-1:0] pc_d, epc_d;
    logic [1:0]        cause_q, cause_d;
    logic              sel_err_q, sel_err_d;
    logic              exc_done_q, exc_done_d;
    logic              sel_ok;
    logic              wr_en;
`ifdef PC_HIST_EN
    logic              hist_push;
`endif

    always_comb begin
        pc_next = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pc_sel == SEL_W'(i)) begin
                pc_next = src_bus[i*DATA_W +: DATA_W];
                sel_ok  = 1'b1;
            end
        end
    end

    assign wr_en = pc_write | (pc_write_cond & branch_taken);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        sel_err_d  = sel_err_q;
        exc_done_d = 1'b0;
`ifdef PC_HIST_EN
        hist_push  = 1'b0;
`endif
        case (state_q)
            EXC_SAVE: begin
                // The fault is flagged after PC was already advanced.
                epc_d   = pc_q - DATA_W'(EPC_OFFSET);
                state_d = EXC_JUMP;
            end
            EXC_JUMP: begin
                pc_d       = VEC_BASE + DATA_W'({cause_q, 2'b00});
                exc_done_d = 1'b1;
                state_d    = RUN;
`ifdef PC_HIST_EN
                hist_push  = 1'b1;
`endif
            end
            default: begin
                if (exc_req) begin
                    cause_d = exc_cause;
                    state_d = EXC_SAVE;
                end else if (eret) begin
                    pc_d = epc_q;
`ifdef PC_HIST_EN
                    hist_push = 1'b1;
`endif
                end else if (wr_en) begin
                    if (sel_ok) begin
                        pc_d = pc_next;
`ifdef PC_HIST_EN
                        hist_push = (pc_sel != '0);
`endif
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            cause_q    <= '0;
            sel_err_q  <= 1'b0;
            exc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            sel_err_q  <= sel_err_d;
            exc_done_q <= exc_done_d;
        end
    end

    assign exc_busy = (state_q == EXC_SAVE) || (state_q == EXC_JUMP);
    assign exc_done = exc_done_q;
    assign sel_err  = sel_err_q;

`ifdef PC_HIST_EN
    pc_hist_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (hist_push),
        .push_data (pc_d),
        .hist_idx  (hist_idx),
        .hist_data (hist_data),
        .hist_cnt  (hist_cnt)
    );
`endif

endmodule
